// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to 5-digit BCD converter
// One input bit per clock; digits saturate to 99999 when the value exceeds MAXVAL.
module bin2bcd_seq #(
  parameter int NBITS  = 17,
  parameter int MAXVAL = 99999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       d0,
  output logic [3:0]       d1,
  output logic [3:0]       d2,
  output logic [3:0]       d3,
  output logic [3:0]       d4
);

  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NBITS-1:0]   sreg_q, sreg_d;
  logic [19:0]        acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [19:0]        digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [19:0]        adj;
  logic [NBITS+19:0]  shifted;
  logic [31:0]        bin_ext;

  assign bin_ext = 32'(bin);

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    adj      = acc_q;
    shifted  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = bin;
          acc_d   = '0;
          cnt_d   = CW'(NBITS);
          sat_d   = (bin_ext > 32'(MAXVAL));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Add-3 correction is applied before the shift so each nibble stays a valid BCD digit.
        for (int i = 0; i < 5; i++) begin
          if (acc_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
          end
        end
        shifted         = {adj, sreg_q} << 1;
        {acc_d, sreg_d} = shifted;
        cnt_d           = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        digits_d = sat_q ? 20'h99999 : acc_q;
        ovf_d    = sat_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign ovf  = ovf_q;
  assign d0   = digits_q[3:0];
  assign d1   = digits_q[7:4];
  assign d2   = digits_q[11:8];
  assign d3   = digits_q[15:12];
  assign d4   = digits_q[19:16];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
module tb_bin2bcd_seq;

  typedef struct {
    logic [16:0] bin;
    logic [19:0] exp_d;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [19:0] d;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] bin;
  logic        busy, done, ovf;
  logic [3:0]  d0, d1, d2, d3, d4;
  logic [19:0] dig;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int done_cyc = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int last_busy = 0;

  exp_t sb[$];
  exp_t hold;
  exp_t e;
  vec_t tbl[10];

  bin2bcd_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .ovf  (ovf),
    .d0   (d0),
    .d1   (d1),
    .d2   (d2),
    .d3   (d3),
    .d4   (d4)
  );

  assign dig = {d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic exp_t ref_model(input int unsigned v);
    exp_t r;
    int unsigned t;
    r.d   = '0;
    r.ovf = 1'b0;
    t     = v;
    if (v > 99999) begin
      r.d   = 20'h99999;
      r.ovf = 1'b1;
    end else begin
      for (int i = 0; i < 5; i++) begin
        r.d[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
    return r;
  endfunction

  // Scoreboard: every done pops one expectation; between dones the outputs must hold the last result.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("digits", 32'(dig), 32'(e.d));
          check("ovf", 32'(ovf), 32'(e.ovf));
          hold = e;
        end
      end else begin
        check("hold_digits", 32'(dig), 32'(hold.d));
        check("hold_ovf", 32'(ovf), 32'(hold.ovf));
      end
      if (busy) begin
        busy_cnt++;
      end else if (busy_cnt != 0) begin
        last_busy = busy_cnt;
        busy_cnt  = 0;
      end
    end
  end

  // Starts at a negedge, returns at the negedge right after done was seen.
  task automatic convert(input logic [16:0] v, input logic [19:0] ed, input logic eo, input string nm);
    int   nd;
    int   t0;
    exp_t x;
    x.d   = ed;
    x.ovf = eo;
    bin   = v;
    start = 1'b1;
    t0    = cyc + 1;
    nd    = n_done;
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && n_done == nd; i++) @(negedge clk);
    if (n_done == nd) begin
      check({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({nm, "_latency"}, 32'(done_cyc - t0), 32'd18);
      check({nm, "_busy_len"}, 32'(last_busy), 32'd18);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int t0;
    int prev;

    tbl[0] = '{17'd12345,  20'h12345, 1'b0};
    tbl[1] = '{17'd99999,  20'h99999, 1'b0};
    tbl[2] = '{17'd100000, 20'h99999, 1'b1};
    tbl[3] = '{17'd131071, 20'h99999, 1'b1};
    tbl[4] = '{17'd0,      20'h00000, 1'b0};
    tbl[5] = '{17'd9,      20'h00009, 1'b0};
    tbl[6] = '{17'd10,     20'h00010, 1'b0};
    tbl[7] = '{17'd1,      20'h00001, 1'b0};
    tbl[8] = '{17'd65535,  20'h65535, 1'b0};
    tbl[9] = '{17'd90909,  20'h90909, 1'b0};

    hold.d   = '0;
    hold.ovf = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_digits", 32'(dig), 32'd0);

    // Release and start on the first posedge; table entries run back-to-back.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      convert(tbl[i].bin, tbl[i].exp_d, tbl[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Input changes and start pulses during a conversion must be ignored.
    repeat (2) @(negedge clk);
    begin
      exp_t x;
      x.d   = 20'h04321;
      x.ovf = 1'b0;
      bin   = 17'd4321;
      start = 1'b1;
      t0    = cyc + 1;
      nd    = n_done;
      sb.push_back(x);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      bin   = 17'd777;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 40 && n_done == nd; i++) @(negedge clk);
      check("inflight_latency", 32'(done_cyc - t0), 32'd18);
      check("inflight_busy_len", 32'(last_busy), 32'd18);
      repeat (25) @(negedge clk);
      check("inflight_single_done", 32'(n_done - nd), 32'd1);
    end

    // Reset in the middle of a conversion aborts it silently.
    begin
      exp_t x;
      x.d   = 20'h54321;
      x.ovf = 1'b0;
      bin   = 17'd54321;
      start = 1'b1;
      nd    = n_done;
      sb.push_back(x);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b0;
      sb.delete();
      hold.d   = '0;
      hold.ovf = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_digits", 32'(dig), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_no_done", 32'(n_done), 32'(nd));
      rst = 1'b1;
      convert(17'd54321, 20'h54321, 1'b0, "after_abort");
    end

    // Continuous start: a new sample is presented on every done.
    repeat (3) @(negedge clk);
    bin   = 17'd0;
    start = 1'b1;
    t0    = cyc + 1;
    nd    = n_done;
    prev  = 0;
    sb.push_back(ref_model(0));
    for (int k = 1; k <= 1000; k++) begin
      for (int i = 0; i < 40 && n_done == nd; i++) @(negedge clk);
      if (n_done == nd) begin
        check("stream_timeout", 32'd0, 32'd1);
        break;
      end
      nd = n_done;
      if (k == 1) check("stream_first_latency", 32'(done_cyc - t0), 32'd18);
      else        check("stream_period", 32'(done_cyc - prev), 32'd19);
      prev = done_cyc;
      if (k < 1000) begin
        bin = 17'(k);
        sb.push_back(ref_model(k));
      end else begin
        start = 1'b0;
      end
    end

    repeat (25) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter NBITS, default 17, giving the width of the binary input.
REQ-002 SHALL have parameter MAXVAL, default 99999, giving the largest value that can be shown on 5 decimal digits.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 SHALL have port: start  input  1  request conversion of bin, sampled on posedge.
REQ-006 SHALL have port: bin  input  NBITS  unsigned binary value to convert.
REQ-007 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when the digit outputs are updated.
REQ-009 SHALL have port: ovf  output  1  high when the last converted bin exceeded MAXVAL.
REQ-010 SHALL have ports: d0, d1, d2, d3, d4  output  4 each  BCD digits, d0 = units, d4 = ten-thousands, each feeding a downstream 7-segment decoder.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL, in IDLE with start=1, capture bin into a shift register, clear the 20-bit BCD accumulator, load iteration counter = NBITS, and go to SHIFT.
REQ-013 SHALL ignore start in SHIFT and DONE; a later change of bin SHALL NOT affect a conversion in flight.
REQ-014 SHALL, in each SHIFT cycle, first add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by 1, then decrement the counter (double-dabble, one bit per clock).
REQ-015 SHALL move from SHIFT to DONE after exactly NBITS SHIFT cycles, i.e. on the cycle the counter reaches 0.
REQ-016 SHALL, in DONE, register d0..d4 from the accumulator, register ovf = (captured bin > MAXVAL), assert done for that one cycle, and return to IDLE.
REQ-017 SHALL, when the captured bin > MAXVAL, drive d4..d0 = 9,9,9,9,9 (saturate) instead of the accumulator contents.
REQ-018 SHALL assert busy during SHIFT and DONE and deassert it in IDLE.
REQ-019 SHALL have a latency, for the default NBITS, of exactly 18 clocks: start sampled at edge N, done high after edge N+18, and new digits visible after edge N+18.
REQ-020 SHALL hold d0..d4 and ovf stable from one done to the next; intermediate accumulator values SHALL never appear on the outputs.
REQ-021 SHALL accept a start in the first IDLE cycle after DONE, giving back-to-back conversions every NBITS+2 clocks.
REQ-022 SHALL treat bin = 0 as a normal conversion: full latency, digits all 0, done pulsed.

Reset
REQ-023 SHALL, while rst=0, asynchronously force state = IDLE, busy=0, done=0, ovf=0, d0..d4=0, counter=0 and accumulator=0.
REQ-024 SHALL, if rst is asserted mid-conversion, abort the conversion with no done pulse and leave the outputs at 0.
REQ-025 SHALL, after rst releases, accept start on the first posedge.

Verification
REQ-026 bench SHALL check: reset, then start with bin=12345 -> done after exactly 18 clocks, d4..d0=1,2,3,4,5, ovf=0.
REQ-027 bench SHALL check: bin=99999 -> digits 9,9,9,9,9, ovf=0; then bin=100000 -> digits 9,9,9,9,9, ovf=1; then bin=131071 -> same, ovf=1.
REQ-028 bench SHALL check: bin=0 -> digits all 0, done after 18 clocks; then bin=9 -> d0=9, others 0; then bin=10 -> d1=1, d0=0.
REQ-029 bench SHALL check: start with 4321, bin changed to 777 and start pulsed at clocks 3 and 10 -> single done, digits 0,4,3,2,1, busy high for 18 clocks.
REQ-030 bench SHALL check: rst pulled low at clock 9 of a conversion of 54321 -> no done, all outputs 0; after release, start with 54321 -> correct result in 18 clocks.
REQ-031 bench SHALL check: start held high continuously with bin stepping 0..999 on each done -> one done every 19 clocks, digits match the decimal value of every sample, compared against a reference model.
